// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and helpers for the FT supervisor and its counters.
// Contents: command opcodes, supervisor FSM states, block-index width,
// and a 3-bit population count used for the two-replicas-lost alarm.
package cv32e40p_ft_pkg;

    localparam int unsigned FT_SUP_BLK_W = 4;

    typedef enum logic [1:0] {
        READ_CNT = 2'd0,
        CLEAR    = 2'd1,
        FORCE    = 2'd2,
        RELEASE  = 2'd3
    } ft_cmd_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ft_sup_state_e;

    function automatic logic [1:0] ft_popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Saturating up-counter for FT error statistics.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : add one this cycle (ignored once all ones)
//   clr_i      : force to zero; wins over inc_i
//   cnt_o      : current count
module cv32e40p_ft_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_supervisor.sv
// Supervisor for NBLK TMR blocks: per-block detected/corrected error
// counters, loss-of-protection flags, and a command port for reading and
// clearing counters and forcing/releasing replica breakage.
// Ports:
//   err_detected_i/err_corrected_i : per-block voter pulses
//   is_broken_i / set_broken_o     : per-block, per-replica flags, bit b*3+r
//   cmd_*                          : valid/ready command request
//   rsp_*                          : one-cycle response strobe, payload, error
//   degraded_o                     : some replica broken (registered)
//   alarm_o                        : sticky, some block lost >= 2 replicas
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | apply side effect of the registered command, capture payload
// RESP  | present response for one cycle
module cv32e40p_ft_supervisor
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned NBLK  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NBLK-1:0]         err_detected_i,
    input  logic [NBLK-1:0]         err_corrected_i,
    input  logic [NBLK*3-1:0]       is_broken_i,
    output logic [NBLK*3-1:0]       set_broken_o,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [FT_SUP_BLK_W-1:0] cmd_blk_i,
    input  logic [1:0]              cmd_rep_i,
    output logic                    rsp_valid_o,
    output logic [2*CNT_W-1:0]      rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    degraded_o,
    output logic                    alarm_o
);

    ft_sup_state_e           state_q, state_d;
    ft_cmd_op_e              op_q;
    logic [FT_SUP_BLK_W-1:0] blk_q;
    logic [1:0]              rep_q;
    logic                    bad_q;
    logic [NBLK*3-1:0]       set_broken_q, set_broken_d;
    logic [2*CNT_W-1:0]      rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    alarm_q, alarm_d;
    logic                    degraded_q;

    logic                    accept;
    logic                    cmd_bad;
    logic                    exec_ok;
    logic                    clr_exec;
    logic [NBLK-1:0]         clr_vec;
    logic [CNT_W-1:0]        det_cnt [NBLK];
    logic [CNT_W-1:0]        cor_cnt [NBLK];
    logic [CNT_W-1:0]        sel_det, sel_cor;
    logic [2:0]              sel_brk;
    logic                    any2;

    // Index validity is judged once at accept so EXEC only needs one flag.
    assign cmd_bad  = (32'(cmd_blk_i) >= NBLK) || (cmd_op_i[1] && (cmd_rep_i == 2'd3));
    assign exec_ok  = (state_q == EXEC) && !bad_q;
    assign clr_exec = exec_ok && (op_q == CLEAR);

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar b = 0; b < NBLK; b++) begin : g_blk
        assign clr_vec[b] = clr_exec && (blk_q == FT_SUP_BLK_W'(b));

        cv32e40p_ft_sat_counter #(.W(CNT_W)) u_det_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (err_detected_i[b]),
            .clr_i (clr_vec[b]),
            .cnt_o (det_cnt[b])
        );

        cv32e40p_ft_sat_counter #(.W(CNT_W)) u_cor_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (err_corrected_i[b]),
            .clr_i (clr_vec[b]),
            .cnt_o (cor_cnt[b])
        );
    end

    always_comb begin
        sel_det = '0;
        sel_cor = '0;
        sel_brk = '0;
        any2    = 1'b0;
        for (int b = 0; b < NBLK; b++) begin
            if (blk_q == FT_SUP_BLK_W'(b)) begin
                sel_det = det_cnt[b];
                sel_cor = cor_cnt[b];
                sel_brk = is_broken_i[b*3 +: 3];
            end
            if (ft_popcnt3(is_broken_i[b*3 +: 3]) >= 2'd2) begin
                any2 = 1'b1;
            end
        end
    end

    always_comb begin
        set_broken_d = set_broken_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        if (state_q == EXEC) begin
            rsp_err_d  = bad_q;
            rsp_data_d = '0;
            if (!bad_q) begin
                unique case (op_q)
                    READ_CNT: rsp_data_d = {sel_det, sel_cor};
                    CLEAR:    rsp_data_d = '0;
                    FORCE, RELEASE: begin
                        // Payload shows the flags before this command takes effect.
                        rsp_data_d = (2*CNT_W)'(sel_brk);
                        for (int b = 0; b < NBLK; b++) begin
                            for (int r = 0; r < 3; r++) begin
                                if ((blk_q == FT_SUP_BLK_W'(b)) && (rep_q == 2'(r))) begin
                                    set_broken_d[b*3 + r] = (op_q == FORCE);
                                end
                            end
                        end
                    end
                    default: rsp_data_d = '0;
                endcase
            end
        end
        // A CLEAR only drops the alarm if no block is still double-broken.
        alarm_d = any2 | (alarm_q & ~clr_exec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= READ_CNT;
            blk_q        <= '0;
            rep_q        <= '0;
            bad_q        <= 1'b0;
            set_broken_q <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            alarm_q      <= 1'b0;
            degraded_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= ft_cmd_op_e'(cmd_op_i);
                blk_q <= cmd_blk_i;
                rep_q <= cmd_rep_i;
                bad_q <= cmd_bad;
            end
            set_broken_q <= set_broken_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            alarm_q      <= alarm_d;
            degraded_q   <= |is_broken_i;
        end
    end

    assign set_broken_o = set_broken_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;
    assign alarm_o      = alarm_q;
    assign degraded_o   = degraded_q;

endmodule
